// File: rtl/axi_read_if.sv
// AXI read-channel bundle (AR + R) between a read master and axi_read_intf.
interface axi_read_if #(
  parameter int unsigned ARID_WIDTH   = 8,
  parameter int unsigned ARADDR_WIDTH = 11,
  parameter int unsigned RDATA_WIDTH  = 64
);
  logic [ARID_WIDTH-1:0]   ARID;
  logic [ARADDR_WIDTH-1:0] ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic [3:0]              ARREGION;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ARID_WIDTH-1:0]   RID;
  logic [RDATA_WIDTH-1:0]  RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_intf.sv
// AXI read slave: turns one AR burst at a time into single-beat internal read
// requests and returns each beat on the R channel. Illegal bursts are answered
// with SLVERR beats without touching the internal read port.
module axi_read_intf #(
  parameter int unsigned ARID_WIDTH   = 8,
  parameter int unsigned ARADDR_WIDTH = 11,
  parameter int unsigned RDATA_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_read_if.slave               axi,
  output logic                    axi_rd_vld,
  output logic [ARADDR_WIDTH-1:0] axi_rd_addr,
  output logic [1:0]              axi_rd_region,
  input  logic [RDATA_WIDTH-1:0]  axi_rd_data,
  input  logic                    axi_rd_data_vld,
  input  logic                    axi_rd_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    arready_q, arready_d;
  logic [ARID_WIDTH-1:0]   id_q, id_d;
  logic [ARADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [1:0]              region_q, region_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_burst_q, err_burst_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rlast_q, rlast_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [RDATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic                    ar_err;
  logic                    wrap_len_ok;
  logic [ARADDR_WIDTH-1:0] step;
  logic [ARADDR_WIDTH-1:0] wrap_mask;
  logic [ARADDR_WIDTH-1:0] incr_addr;
  logic [ARADDR_WIDTH-1:0] next_addr;

  // Classify the incoming AR request and compute the next beat address.
  always_comb begin
    wrap_len_ok = (axi.ARLEN == 8'd1) || (axi.ARLEN == 8'd3) ||
                  (axi.ARLEN == 8'd7) || (axi.ARLEN == 8'd15);
    ar_err      = (axi.ARSIZE > 3'd3) || (axi.ARBURST == 2'b11) ||
                  (axi.ARREGION[1:0] == 2'b11) ||
                  ((axi.ARBURST == 2'b10) && !wrap_len_ok);
    step        = ARADDR_WIDTH'(1) << size_q;
    // Wrap window is (len+1) << size bytes; only power-of-two lengths reach here.
    wrap_mask   = ((ARADDR_WIDTH'(len_q) + ARADDR_WIDTH'(1)) << size_q) - ARADDR_WIDTH'(1);
    incr_addr   = addr_q + step;
    unique case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  // Next-state logic for the burst FSM and the registered R/AR outputs.
  always_comb begin
    state_d     = state_q;
    arready_d   = arready_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    region_d    = region_q;
    cnt_d       = cnt_q;
    err_burst_d = err_burst_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (arready_q && axi.ARVALID) begin
          id_d        = axi.ARID;
          addr_d      = axi.ARADDR;
          len_d       = axi.ARLEN;
          size_d      = axi.ARSIZE;
          burst_d     = axi.ARBURST;
          region_d    = axi.ARREGION[1:0];
          cnt_d       = 8'd0;
          arready_d   = 1'b0;
          err_burst_d = ar_err;
          if (ar_err) begin
            // First error beat goes straight out; no internal request is made.
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = 2'b10;
            rlast_d  = (axi.ARLEN == 8'd0);
            state_d  = StResp;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (err_burst_q) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = 2'b10;
          rlast_d  = (cnt_q == len_q);
          state_d  = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (axi_rd_data_vld) begin
          rvalid_d = 1'b1;
          rdata_d  = axi_rd_data;
          rresp_d  = axi_rd_err ? 2'b10 : 2'b00;
          rlast_d  = (cnt_q == len_q);
          state_d  = StResp;
        end
      end
      StResp: begin
        if (rvalid_q && axi.RREADY) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = StIdle;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = next_addr;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      arready_q   <= 1'b1;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= 2'b00;
      region_q    <= 2'b00;
      cnt_q       <= 8'd0;
      err_burst_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      region_q    <= region_d;
      cnt_q       <= cnt_d;
      err_burst_q <= err_burst_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  // Request pulse is decoded from REQ so it lands one cycle after the handshake.
  always_comb begin
    axi_rd_vld    = (state_q == StReq) && !err_burst_q;
    axi_rd_addr   = addr_q;
    axi_rd_region = region_q;
    axi.ARREADY   = arready_q;
    axi.RID       = id_q;
    axi.RDATA     = rdata_q;
    axi.RRESP     = rresp_q;
    axi.RLAST     = rlast_q;
    axi.RVALID    = rvalid_q;
  end

endmodule

// File: tb/tb_axi_read_intf.sv
// Directed bench for axi_read_intf with queue-based scoreboard and monitors.
module tb_axi_read_intf;
  localparam int unsigned IW = 8;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_read_if #(.ARID_WIDTH(IW), .ARADDR_WIDTH(AW), .RDATA_WIDTH(DW)) bus ();

  logic          axi_rd_vld;
  logic [AW-1:0] axi_rd_addr;
  logic [1:0]    axi_rd_region;
  logic [DW-1:0] axi_rd_data;
  logic          axi_rd_data_vld;
  logic          axi_rd_err;

  axi_read_intf #(.ARID_WIDTH(IW), .ARADDR_WIDTH(AW), .RDATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .axi             (bus),
    .axi_rd_vld      (axi_rd_vld),
    .axi_rd_addr     (axi_rd_addr),
    .axi_rd_region   (axi_rd_region),
    .axi_rd_data     (axi_rd_data),
    .axi_rd_data_vld (axi_rd_data_vld),
    .axi_rd_err      (axi_rd_err)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    region;
  } req_t;

  beat_t exp_beat_q[$];
  req_t  exp_req_q[$];
  logic  err_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;
  int    resp_delay = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model content: a fixed function of the request address.
  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
    return {16'hD00D, 5'b0, a, 32'h1234_5678 ^ {21'b0, a}};
  endfunction

  task automatic push_ok(input logic [IW-1:0] id, input logic [AW-1:0] a,
                         input logic [1:0] region, input logic err, input logic last);
    req_t  r;
    beat_t b;
    r.addr = a;
    r.region = region;
    exp_req_q.push_back(r);
    err_q.push_back(err);
    b.id = id;
    b.data = mkdata(a);
    b.resp = err ? 2'b10 : 2'b00;
    b.last = last;
    exp_beat_q.push_back(b);
  endtask

  task automatic push_err_beat(input logic [IW-1:0] id, input logic last);
    beat_t b;
    b.id = id;
    b.data = '0;
    b.resp = 2'b10;
    b.last = last;
    exp_beat_q.push_back(b);
  endtask

  task automatic ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [3:0] region);
    bit ok;
    ok = 1'b0;
    bus.ARID = id;
    bus.ARADDR = a;
    bus.ARLEN = len;
    bus.ARSIZE = size;
    bus.ARBURST = burst;
    bus.ARREGION = region;
    bus.ARVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ARREADY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 bus.ARVALID = 1'b0;
    check("ar_handshake", {63'b0, ok}, 64'd1);
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_beat_q.size() == 0 && exp_req_q.size() == 0 && bus.ARREADY) begin
        done = 1'b1;
        break;
      end
    end
    check("burst_done", {63'b0, done}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Internal read port monitor: every request must match the expected address list.
  initial begin
    req_t r;
    forever begin
      @(negedge clk);
      if (!rst && axi_rd_vld) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_req: got addr %0h expected none", axi_rd_addr);
        end else begin
          r = exp_req_q.pop_front();
          check("rd_addr", 64'(axi_rd_addr), 64'(r.addr));
          check("rd_region", 64'(axi_rd_region), 64'(r.region));
        end
        check("no_rvalid_with_req", {63'b0, bus.RVALID}, 64'd0);
      end
    end
  end

  // R channel monitor: every accepted beat is compared to the scoreboard head.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst && bus.RVALID && bus.RREADY) begin
        beats_seen++;
        if (exp_beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h expected none", bus.RDATA);
        end else begin
          b = exp_beat_q.pop_front();
          check("rid", 64'(bus.RID), 64'(b.id));
          check("rdata", bus.RDATA, b.data);
          check("rresp", 64'(bus.RRESP), 64'(b.resp));
          check("rlast", {63'b0, bus.RLAST}, {63'b0, b.last});
        end
      end
    end
  end

  // Memory responder: answers each request after resp_delay cycles.
  initial begin
    logic [AW-1:0] a;
    logic          e;
    int            d;
    axi_rd_data = '0;
    axi_rd_data_vld = 1'b0;
    axi_rd_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && axi_rd_vld) begin
        a = axi_rd_addr;
        e = (err_q.size() != 0) ? err_q.pop_front() : 1'b0;
        d = resp_delay;
        repeat (d) @(posedge clk);
        #1;
        axi_rd_data = mkdata(a);
        axi_rd_err = e;
        axi_rd_data_vld = 1'b1;
        @(posedge clk);
        #1;
        axi_rd_data_vld = 1'b0;
        axi_rd_err = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] snap_data;
    logic          snap_last;
    logic [1:0]    snap_resp;
    bit            ok;
    bit            saw;

    rst = 1'b1;
    bus.ARID = '0;
    bus.ARADDR = '0;
    bus.ARLEN = '0;
    bus.ARSIZE = '0;
    bus.ARBURST = '0;
    bus.ARREGION = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", {63'b0, bus.ARREADY}, 64'd1);
    check("rst_rvalid", {63'b0, bus.RVALID}, 64'd0);
    check("rst_rlast", {63'b0, bus.RLAST}, 64'd0);
    check("rst_rresp", 64'(bus.RRESP), 64'd0);
    check("rst_rdata", bus.RDATA, 64'd0);
    check("rst_rid", 64'(bus.RID), 64'd0);
    check("rst_rd_vld", {63'b0, axi_rd_vld}, 64'd0);
    check("rst_rd_addr", 64'(axi_rd_addr), 64'd0);
    check("rst_rd_region", 64'(axi_rd_region), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // INCR, 8-byte beats.
    push_ok(8'h5A, 11'h010, 2'd1, 1'b0, 1'b0);
    push_ok(8'h5A, 11'h018, 2'd1, 1'b0, 1'b0);
    push_ok(8'h5A, 11'h020, 2'd1, 1'b0, 1'b0);
    push_ok(8'h5A, 11'h028, 2'd1, 1'b0, 1'b1);
    ar(8'h5A, 11'h010, 8'd3, 3'd3, 2'b01, 4'h1);
    wait_done();

    // WRAP over a 32-byte window; upper region bits ignored.
    resp_delay = 3;
    push_ok(8'h33, 11'h038, 2'd2, 1'b0, 1'b0);
    push_ok(8'h33, 11'h020, 2'd2, 1'b0, 1'b0);
    push_ok(8'h33, 11'h028, 2'd2, 1'b0, 1'b0);
    push_ok(8'h33, 11'h030, 2'd2, 1'b0, 1'b1);
    ar(8'h33, 11'h038, 8'd3, 3'd3, 2'b10, 4'h6);
    wait_done();
    resp_delay = 1;

    // Back-pressure on beat 2.
    push_ok(8'h77, 11'h100, 2'd0, 1'b0, 1'b0);
    push_ok(8'h77, 11'h104, 2'd0, 1'b0, 1'b0);
    push_ok(8'h77, 11'h108, 2'd0, 1'b0, 1'b1);
    beats_seen = 0;
    ar(8'h77, 11'h100, 8'd2, 3'd2, 2'b01, 4'h0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (beats_seen == 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("stall_beat1_seen", {63'b0, ok}, 64'd1);
    @(posedge clk);
    #1 bus.RREADY = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.RVALID) begin
        ok = 1'b1;
        break;
      end
    end
    check("stall_beat2_valid", {63'b0, ok}, 64'd1);
    snap_data = bus.RDATA;
    snap_last = bus.RLAST;
    snap_resp = bus.RRESP;
    check("stall_beat2_data", snap_data, mkdata(11'h104));
    repeat (5) begin
      @(negedge clk);
      check("stall_rvalid", {63'b0, bus.RVALID}, 64'd1);
      check("stall_rdata", bus.RDATA, snap_data);
      check("stall_rlast", {63'b0, bus.RLAST}, {63'b0, snap_last});
      check("stall_rresp", 64'(bus.RRESP), 64'(snap_resp));
      check("stall_no_rd_vld", {63'b0, axi_rd_vld}, 64'd0);
    end
    @(posedge clk);
    #1 bus.RREADY = 1'b1;
    wait_done();

    // ARSIZE too large: two SLVERR beats, no internal requests.
    push_err_beat(8'h44, 1'b0);
    push_err_beat(8'h44, 1'b1);
    ar(8'h44, 11'h080, 8'd1, 3'd4, 2'b01, 4'h0);
    wait_done();
    check("err_arready_after", {63'b0, bus.ARREADY}, 64'd1);

    // WRAP with illegal length of 3 beats.
    push_err_beat(8'h45, 1'b0);
    push_err_beat(8'h45, 1'b0);
    push_err_beat(8'h45, 1'b1);
    ar(8'h45, 11'h040, 8'd2, 3'd3, 2'b10, 4'h0);
    wait_done();

    // Reserved region: single SLVERR beat.
    push_err_beat(8'h46, 1'b1);
    ar(8'h46, 11'h040, 8'd0, 3'd3, 2'b01, 4'h3);
    wait_done();

    // SLVERR on the first beat does not abort the burst.
    push_ok(8'h21, 11'h200, 2'd0, 1'b1, 1'b0);
    push_ok(8'h21, 11'h208, 2'd0, 1'b0, 1'b0);
    push_ok(8'h21, 11'h210, 2'd0, 1'b0, 1'b1);
    ar(8'h21, 11'h200, 8'd2, 3'd3, 2'b01, 4'h0);
    wait_done();

    // FIXED keeps the address.
    push_ok(8'h0F, 11'h044, 2'd1, 1'b0, 1'b0);
    push_ok(8'h0F, 11'h044, 2'd1, 1'b0, 1'b1);
    ar(8'h0F, 11'h044, 8'd1, 3'd2, 2'b00, 4'h1);
    wait_done();

    // INCR wraps modulo the address space.
    push_ok(8'hE1, 11'h7F8, 2'd0, 1'b0, 1'b0);
    push_ok(8'hE1, 11'h000, 2'd0, 1'b0, 1'b1);
    ar(8'hE1, 11'h7F8, 8'd1, 3'd3, 2'b01, 4'h0);
    wait_done();

    // ARLEN=0 single beat.
    push_ok(8'hC3, 11'h7FF, 2'd2, 1'b0, 1'b1);
    ar(8'hC3, 11'h7FF, 8'd0, 3'd0, 2'b01, 4'h2);
    wait_done();

    // Reset while waiting for data: the late return must not surface.
    resp_delay = 6;
    exp_req_q.push_back('{addr: 11'h300, region: 2'd0});
    err_q.push_back(1'b0);
    ar(8'h99, 11'h300, 8'd0, 3'd3, 2'b01, 4'h0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_req_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_test_req_seen", {63'b0, ok}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.RVALID) saw = 1'b1;
    end
    check("rst_mid_no_rvalid", {63'b0, saw}, 64'd0);
    check("rst_mid_arready", {63'b0, bus.ARREADY}, 64'd1);
    check("rst_mid_rid", 64'(bus.RID), 64'd0);
    resp_delay = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
